axi4_slave_wr_ctrl: RTL and testbench

Write-channel controller of the AXI4 slave DUT. It terminates the AW, W and B channels driven by the verification master and converts each accepted burst into per-beat word writes on a local memory port. It supports FIXED, INCR and WRAP bursts, honours WSTRB, and returns OKAY or SLVERR on B with the latched AWID.

---
 rtl/axi_slave_pkg.sv | 21 ++
 rtl/axi_burst_addr_gen.sv | 35 +++
 rtl/axi4_slave_wr_ctrl.sv | 140 ++++++++++++++
 tb/tb_axi4_slave_wr_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI4 slave channel controllers.
package axi_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] MAX_SIZE    = 3'd2;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; shared by the
// write and read controllers.
module axi_burst_addr_gen
  import axi_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  burst_e                burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] total;
  logic [ADDR_WIDTH-1:0] lower;
  logic [ADDR_WIDTH-1:0] step;

  // INCR re-aligns an unaligned start; WRAP folds back to the window base.
  always_comb begin
    bytes     = ADDR_WIDTH'(1) << size;
    total     = bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
    lower     = start_addr & ~(total - ADDR_WIDTH'(1));
    step      = cur_addr + bytes;
    next_addr = cur_addr;
    case (burst)
      BURST_INCR: next_addr = (cur_addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
      BURST_WRAP: next_addr = (step == lower + total) ? lower : step;
      default:    next_addr = cur_addr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_wr_ctrl.sv
// AXI4 slave write-channel controller: terminates AW/W/B and turns each burst
// into per-beat word writes on the local memory port.
module axi4_slave_wr_ctrl
  import axi_slave_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   DATA_WIDTH = 32,
  parameter int                   ID_WIDTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE  = '0,
  parameter int                   MEM_DEPTH  = 1024
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [ADDR_WIDTH-1:0]        AWADDR,
  input  logic [ID_WIDTH-1:0]          AWID,
  input  logic [7:0]                   AWLEN,
  input  logic [2:0]                   AWSIZE,
  input  logic [1:0]                   AWBURST,
  input  logic                         WVALID,
  output logic                         WREADY,
  input  logic [DATA_WIDTH-1:0]        WDATA,
  input  logic [3:0]                   WSTRB,
  input  logic                         WLAST,
  output logic                         BVALID,
  input  logic                         BREADY,
  output logic [ID_WIDTH-1:0]          BID,
  output logic [1:0]                   BRESP,
  output logic                         mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic [3:0]                   mem_wstrb
);

  localparam int                  IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

  state_e                state;
  logic                  rst_done;
  logic                  err;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] start_q;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic [7:0]            len_q;
  logic [7:0]            count;
  logic [2:0]            size_q;
  burst_e                burst_q;
  logic                  w_hs;
  logic                  in_range;
  logic                  last_beat;
  logic                  wlast_err;
  logic                  wrap_len_ok;
  logic                  setup_err;

  assign AWREADY = (state == ST_IDLE) && rst_done;
  assign WREADY  = (state == ST_DATA);
  assign BVALID  = (state == ST_RESP);

  assign offset    = cur_addr - MEM_BASE;
  assign in_range  = (cur_addr >= MEM_BASE) && ({1'b0, offset} < MEM_BYTES);
  assign mem_addr  = IDX_W'(offset >> 2);
  assign mem_wdata = WDATA;
  assign mem_wstrb = WSTRB;
  assign w_hs      = WVALID && WREADY;
  assign mem_we    = w_hs && !err && in_range;

  // A burst closes on whichever of beat AWLEN or WLAST comes first; disagreement is an error.
  assign last_beat = (count == len_q) || WLAST;
  assign wlast_err = (count == len_q) != WLAST;

  assign align_mask  = ~({ADDR_WIDTH{1'b1}} << AWSIZE);
  assign wrap_len_ok = (AWLEN == 8'd1) || (AWLEN == 8'd3) || (AWLEN == 8'd7) || (AWLEN == 8'd15);
  assign setup_err   = (AWSIZE > MAX_SIZE) || (AWBURST == BURST_RSVD) ||
                       ((AWBURST == BURST_WRAP) && (!wrap_len_ok || ((AWADDR & align_mask) != '0)));

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .cur_addr  (cur_addr),
    .start_addr(start_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      rst_done <= 1'b0;
      err      <= 1'b0;
      id_q     <= '0;
      start_q  <= '0;
      cur_addr <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= BURST_FIXED;
      count    <= '0;
      BID      <= '0;
      BRESP    <= RESP_OKAY;
    end else begin
      rst_done <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (AWVALID && AWREADY) begin
            id_q     <= AWID;
            start_q  <= AWADDR;
            cur_addr <= AWADDR;
            len_q    <= AWLEN;
            size_q   <= AWSIZE;
            burst_q  <= burst_e'(AWBURST);
            count    <= '0;
            err      <= setup_err;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            err <= err || !in_range || wlast_err;
            if (last_beat) begin
              state <= ST_RESP;
              BID   <= id_q;
              BRESP <= (err || !in_range || wlast_err) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              count    <= count + 8'd1;
              cur_addr <= next_addr;
            end
          end
        end
        ST_RESP: begin
          if (BREADY) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_slave_wr_ctrl.sv
// Bench for axi4_slave_wr_ctrl: directed vector table, hand-written corner
// sequences and random bursts checked against a beat-level memory model.
module tb_axi4_slave_wr_ctrl;
  import axi_slave_pkg::*;

  localparam int DEPTH = 1024;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] AWADDR = '0;
  logic [3:0]  AWID = '0;
  logic [7:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  axi4_slave_wr_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_BASE(32'h0), .MEM_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct packed {
    logic [31:0]      addr;
    logic [3:0]       id;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [7:0]       wlast_at;
    logic [3:0][3:0]  strb;
    logic [1:0]       exp_resp;
    logic [2:0]       exp_n;
    logic [3:0][9:0]  exp_addr;
  } vec_t;

  wr_t         got_q[$];
  wr_t         exp_q[$];
  vec_t        vecs[8];
  logic [31:0] beat_data[256];
  logic [3:0]  beat_strb[256];
  logic [3:0]  got_bid;
  logic [1:0]  got_resp;
  int          checks = 0;
  int          errors = 0;

  always @(negedge CLK) if (mem_we) got_q.push_back({mem_addr, mem_wdata, mem_wstrb});

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic aw_phase(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    AWVALID = 1'b1; AWADDR = addr; AWID = id; AWLEN = len; AWSIZE = size; AWBURST = burst;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK); ok = AWREADY;
      @(posedge CLK);
      if (ok) break;
    end
    #1 AWVALID = 1'b0;
    if (!ok) checkOutput("aw_timeout", 0, 1);
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    bit ok = 0;
    WVALID = 1'b1; WDATA = data; WSTRB = strb; WLAST = last;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK); ok = WREADY;
      @(posedge CLK);
      if (ok) break;
    end
    #1 WVALID = 1'b0; WLAST = 1'b0;
    if (!ok) checkOutput("w_timeout", 0, 1);
  endtask

  task automatic b_phase(input int stall, input logic [3:0] eid, input logic [1:0] eresp);
    bit ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (BVALID) begin ok = 1; break; end
    end
    if (!ok) begin
      checkOutput("b_timeout", 0, 1);
      return;
    end
    got_bid = BID; got_resp = BRESP;
    for (int k = 0; k < stall; k++) begin
      @(negedge CLK);
      checkOutput("stall_bvalid", BVALID, 1);
      checkOutput("stall_bid", BID, eid);
      checkOutput("stall_bresp", BRESP, eresp);
      checkOutput("stall_awready", AWREADY, 0);
    end
    BREADY = 1'b1;
    @(posedge CLK);
    #1 BREADY = 1'b0;
    checkOutput("bvalid_drop", BVALID, 0);
  endtask

  // One well-behaved master burst; WLAST on beat wlast_at (beyond AWLEN means never).
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int wlast_at,
                               input int stall, input logic [1:0] eresp);
    int nb;
    nb = (wlast_at < int'(len)) ? wlast_at + 1 : int'(len) + 1;
    got_q.delete();
    aw_phase(addr, id, len, size, burst);
    for (int b = 0; b < nb; b++) w_beat(beat_data[b], beat_strb[b], b == wlast_at);
    b_phase(stall, id, eresp);
  endtask

  // Beat i address from the burst rules, then range/error bookkeeping.
  function automatic logic [1:0] model_burst(input logic [31:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int wlast_at);
    longint la, bytes, total, lower, ai;
    int     last;
    bit     err;
    wr_t    w;
    la    = longint'(a);
    bytes = longint'(1) << size;
    total = bytes * (longint'(len) + 1);
    lower = la - (la % total);
    last  = (wlast_at < int'(len)) ? wlast_at : int'(len);
    err   = (size > 3'd2) || (burst == 2'b11) ||
            (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ||
            (burst == 2'b10 && (la % bytes) != 0);
    exp_q.delete();
    for (int i = 0; i <= last; i++) begin
      case (burst)
        2'b00:   ai = la;
        2'b01:   ai = (i == 0) ? la : (la - (la % bytes)) + longint'(i) * bytes;
        default: ai = lower + ((la - lower) + longint'(i) * bytes) % total;
      endcase
      ai = ai % (longint'(1) << 32);
      if (ai >= 4 * DEPTH) err = 1;
      else if (!err) begin
        w.addr = 10'(ai >> 2); w.data = beat_data[i]; w.strb = beat_strb[i];
        exp_q.push_back(w);
      end
    end
    if (wlast_at != int'(len)) err = 1;
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

  task automatic compare_writes(input string tag);
    checkOutput({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        checkOutput($sformatf("%s_addr%0d", tag, i), got_q[i].addr, exp_q[i].addr);
        checkOutput($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
        checkOutput($sformatf("%s_strb%0d", tag, i), got_q[i].strb, exp_q[i].strb);
      end
    end
  endtask

  initial begin
    logic [1:0]  eresp;
    logic [31:0] ra;
    logic [7:0]  rlen;
    logic [2:0]  rsize;
    logic [1:0]  rburst;
    logic [3:0]  rid;
    int          rwl;

    vecs[0] = '{addr:32'h10, id:4'd5, len:8'd3, size:3'd2, burst:2'b01, wlast_at:8'd3,
                strb:{4'hF,4'hF,4'hF,4'hF}, exp_resp:2'b00, exp_n:3'd4, exp_addr:{10'd7,10'd6,10'd5,10'd4}};
    vecs[1] = '{addr:32'h38, id:4'd2, len:8'd3, size:3'd2, burst:2'b10, wlast_at:8'd3,
                strb:{4'hF,4'hF,4'hF,4'hF}, exp_resp:2'b00, exp_n:3'd4, exp_addr:{10'd13,10'd12,10'd15,10'd14}};
    vecs[2] = '{addr:32'h20, id:4'd7, len:8'd2, size:3'd2, burst:2'b00, wlast_at:8'd2,
                strb:{4'h8,4'h4,4'h2,4'h1}, exp_resp:2'b00, exp_n:3'd3, exp_addr:{10'd0,10'd8,10'd8,10'd8}};
    vecs[3] = '{addr:32'h40, id:4'd1, len:8'd3, size:3'd2, burst:2'b01, wlast_at:8'd1,
                strb:{4'hF,4'hF,4'hF,4'hF}, exp_resp:2'b10, exp_n:3'd2, exp_addr:{10'd0,10'd0,10'd17,10'd16}};
    vecs[4] = '{addr:32'h50, id:4'd3, len:8'd1, size:3'd2, burst:2'b11, wlast_at:8'd1,
                strb:{4'hF,4'hF,4'hF,4'hF}, exp_resp:2'b10, exp_n:3'd0, exp_addr:'0};
    vecs[5] = '{addr:32'h1000, id:4'd4, len:8'd0, size:3'd2, burst:2'b01, wlast_at:8'd0,
                strb:{4'hF,4'hF,4'hF,4'hF}, exp_resp:2'b10, exp_n:3'd0, exp_addr:'0};
    vecs[6] = '{addr:32'h80, id:4'd6, len:8'd1, size:3'd2, burst:2'b01, wlast_at:8'hFF,
                strb:{4'hF,4'hF,4'hF,4'hF}, exp_resp:2'b10, exp_n:3'd2, exp_addr:{10'd0,10'd0,10'd33,10'd32}};
    vecs[7] = '{addr:32'h32, id:4'd8, len:8'd3, size:3'd2, burst:2'b10, wlast_at:8'd3,
                strb:{4'hF,4'hF,4'hF,4'hF}, exp_resp:2'b10, exp_n:3'd0, exp_addr:'0};

    repeat (2) @(negedge CLK);
    checkOutput("rst_awready", AWREADY, 0);
    checkOutput("rst_wready", WREADY, 0);
    checkOutput("rst_bvalid", BVALID, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_bid", BID, 0);
    checkOutput("rst_bresp", BRESP, 0);
    RST = 1'b1;
    #1 checkOutput("awready_before_edge", AWREADY, 0);
    @(posedge CLK);
    #1 checkOutput("awready_after_edge", AWREADY, 1);

    for (int v = 0; v < 8; v++) begin
      for (int b = 0; b < 4; b++) begin
        beat_data[b] = 32'hA0 + b;
        beat_strb[b] = vecs[v].strb[b];
      end
      applyStimulus(vecs[v].addr, vecs[v].id, vecs[v].len, vecs[v].size, vecs[v].burst,
                    int'(vecs[v].wlast_at), 0, vecs[v].exp_resp);
      checkOutput($sformatf("vec%0d_nwr", v), got_q.size(), vecs[v].exp_n);
      for (int i = 0; i < int'(vecs[v].exp_n); i++) begin
        if (i < got_q.size()) begin
          checkOutput($sformatf("vec%0d_addr%0d", v, i), got_q[i].addr, vecs[v].exp_addr[i]);
          checkOutput($sformatf("vec%0d_data%0d", v, i), got_q[i].data, 32'hA0 + i);
          checkOutput($sformatf("vec%0d_strb%0d", v, i), got_q[i].strb, vecs[v].strb[i]);
        end
      end
      checkOutput($sformatf("vec%0d_bid", v), got_bid, vecs[v].id);
      checkOutput($sformatf("vec%0d_bresp", v), got_resp, vecs[v].exp_resp);
    end

    // B backpressure: response must hold and AW must stay blocked.
    beat_data[0] = 32'h1111_0000; beat_strb[0] = 4'h3;
    beat_data[1] = 32'h2222_0000; beat_strb[1] = 4'hC;
    applyStimulus(32'h200, 4'hA, 8'd1, 3'd2, 2'b01, 1, 5, RESP_OKAY);
    checkOutput("bp_awready_after_b", AWREADY, 1);
    checkOutput("bp_bid", got_bid, 4'hA);
    checkOutput("bp_bresp", got_resp, RESP_OKAY);
    checkOutput("bp_nwr", got_q.size(), 2);

    // Reset in the middle of an 8-beat burst.
    got_q.delete();
    aw_phase(32'h100, 4'h9, 8'd7, 3'd2, 2'b01);
    w_beat(32'hDEAD_0000, 4'hF, 1'b0);
    w_beat(32'hDEAD_0001, 4'hF, 1'b0);
    WVALID = 1'b1; WDATA = 32'hDEAD_0002; WSTRB = 4'hF;
    #2 RST = 1'b0;
    #1;
    checkOutput("mid_awready", AWREADY, 0);
    checkOutput("mid_wready", WREADY, 0);
    checkOutput("mid_bvalid", BVALID, 0);
    checkOutput("mid_mem_we", mem_we, 0);
    checkOutput("mid_bid", BID, 0);
    checkOutput("mid_bresp", BRESP, 0);
    checkOutput("mid_mem_addr", mem_addr, 0);
    WVALID = 1'b0;
    checkOutput("mid_nwr", got_q.size(), 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checkOutput("mid_no_bvalid", BVALID, 0);
    end
    RST = 1'b1;
    #1 checkOutput("mid_awready_release", AWREADY, 0);
    @(posedge CLK);
    #1 checkOutput("mid_awready_edge", AWREADY, 1);
    for (int b = 0; b < 4; b++) begin beat_data[b] = 32'hB0 + b; beat_strb[b] = 4'hF; end
    eresp = model_burst(32'h300, 8'd3, 3'd2, 2'b01, 3);
    applyStimulus(32'h300, 4'h3, 8'd3, 3'd2, 2'b01, 3, 0, eresp);
    compare_writes("post_rst");
    checkOutput("post_rst_bresp", got_resp, RESP_OKAY);
    checkOutput("post_rst_bid", got_bid, 4'h3);

    for (int t = 0; t < 40; t++) begin
      rburst = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rsize  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if (rburst == 2'b10 && $urandom_range(0, 7) != 0) rlen = 8'((2 << $urandom_range(0, 3)) - 1);
      else rlen = 8'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 32'(4096 - $urandom_range(1, 40)) : 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 5) != 0) ra = ra & ~((32'd1 << rsize) - 32'd1);
      rwl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(rlen) + 1)) : int'(rlen);
      rid = 4'($urandom);
      for (int b = 0; b < 17; b++) begin beat_data[b] = $urandom; beat_strb[b] = 4'($urandom); end
      eresp = model_burst(ra, rlen, rsize, rburst, rwl);
      applyStimulus(ra, rid, rlen, rsize, rburst, rwl, $urandom_range(0, 2), eresp);
      compare_writes($sformatf("rnd%0d", t));
      checkOutput($sformatf("rnd%0d_bid", t), got_bid, rid);
      checkOutput($sformatf("rnd%0d_bresp", t), got_resp, eresp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
